pipe_stage_skid: RTL and testbench

- Generalised pipeline stage register carrying NUM_CH data channels of DATA_W bits each.
- Supports flush (`clr`) and stall (`en`) as the existing stage registers do.
- Adds a valid/ready handshake on both sides and an optional 1-entry skid buffer, so `in_ready` is registered and back-pressure does not form a combinational path through the stage.
- Sits between any two pipeline stages: IF/ID, ID/EX, EX/MEM or MEM/WB.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_slot.sv | 40 ++++
 rtl/pipe_stage_skid.sv | 142 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline stage register.
//   pipe_state_e : occupancy state of a stage (empty, main only, main + skid)
//   STALL_CNT_W  : width of the back-pressure counter
//   bus_w()      : width of a packed multi-channel data bus
package pipe_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } pipe_state_e;

  localparam int unsigned STALL_CNT_W = 16;

  function automatic int unsigned bus_w(input int unsigned data_w, input int unsigned num_ch);
    return data_w * num_ch;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One packed multi-channel data register with clear, load and hold.
//   clk_i : clock
//   clr_i : synchronous clear; every channel takes CLR_VAL (wins over ld_i)
//   ld_i  : load d_i
//   d_i   : packed NUM_CH*DATA_W input
//   q_o   : register contents
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       NUM_CH  = 3,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic                                clk_i,
  input  logic                                clr_i,
  input  logic                                ld_i,
  input  logic [bus_w(DATA_W, NUM_CH)-1:0]    d_i,
  output logic [bus_w(DATA_W, NUM_CH)-1:0]    q_o
);

  localparam int unsigned BusW = bus_w(DATA_W, NUM_CH);

  logic [BusW-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = {NUM_CH{CLR_VAL}};
    end else if (ld_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, flush, stall and an
// optional one-entry skid buffer.
//   clk, reset (sync, active-high), clr (flush), en (0 = stall)
//   in_valid / in_data / in_ready   : upstream handshake
//   out_valid / out_data / out_ready: downstream handshake
//   occ       : entries held (0..2)
//   stall_cnt : saturating count of back-pressured cycles
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       NUM_CH  = 3,
  parameter bit                SKID_EN = 1'b1,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clr,
  input  logic                             en,
  input  logic                             in_valid,
  input  logic [bus_w(DATA_W, NUM_CH)-1:0] in_data,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic [bus_w(DATA_W, NUM_CH)-1:0] out_data,
  input  logic                             out_ready,
  output logic [1:0]                       occ,
  output logic [STALL_CNT_W-1:0]           stall_cnt
);

  localparam int unsigned BusW   = bus_w(DATA_W, NUM_CH);
  localparam logic [BusW-1:0] ClrBus = {NUM_CH{CLR_VAL}};

  pipe_state_e            state_q, state_d;
  logic                   main_valid, skid_valid;
  logic                   push, pop, flush;
  logic                   main_ld;
  logic [BusW-1:0]        main_d, skid_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign flush      = reset | clr;
  assign main_valid = (state_q != StEmpty);
  assign skid_valid = (state_q == StSkid);

  // With the skid buffer in_ready comes only from registered state, breaking the
  // combinational ready path; without it, a full stage can accept only if it drains.
  always_comb begin
    if (SKID_EN) begin
      in_ready = en & ~skid_valid;
    end else begin
      in_ready = en & (~main_valid | out_ready);
    end
  end

  assign push = in_valid & in_ready;
  assign pop  = main_valid & out_ready & en;

  // en=0 forces push=pop=0, so the FSM holds without an explicit stall branch.
  always_comb begin
    state_d = state_q;
    main_ld = 1'b0;
    main_d  = in_data;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (push) begin
            state_d = StFull;
            main_ld = 1'b1;
          end
        end
        StFull: begin
          if (push && pop) begin
            main_ld = 1'b1;
          end else if (push && SKID_EN) begin
            state_d = StSkid;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StSkid: begin
          if (pop) begin
            state_d = StFull;
            main_ld = 1'b1;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!clr && en && main_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StEmpty;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  pipe_slot #(
    .DATA_W  (DATA_W),
    .NUM_CH  (NUM_CH),
    .CLR_VAL (CLR_VAL)
  ) u_main (
    .clk_i (clk),
    .clr_i (flush),
    .ld_i  (main_ld),
    .d_i   (main_d),
    .q_o   (out_data)
  );

  if (SKID_EN) begin : g_skid
    pipe_slot #(
      .DATA_W  (DATA_W),
      .NUM_CH  (NUM_CH),
      .CLR_VAL (CLR_VAL)
    ) u_skid (
      .clk_i (clk),
      .clr_i (flush),
      .ld_i  ((state_q == StFull) && push && !pop),
      .d_i   (in_data),
      .q_o   (skid_q)
    );
  end else begin : g_no_skid
    assign skid_q = ClrBus;
  end

  assign out_valid = main_valid;
  assign occ       = {1'b0, main_valid} + {1'b0, skid_valid};
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: instance 0 with the skid buffer, instance 1 without.
// Both share stimulus; each is checked against a FIFO-style reference model.
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int NCH = 3;
  localparam int BW = DW * NCH;
  localparam logic [DW-1:0] CLRV = 32'hC1C1_0F0F;
  localparam logic [BW-1:0] CLRB = {NCH{CLRV}};

  logic          clk = 1'b0;
  logic          reset, clr, en, in_valid, out_ready;
  logic [BW-1:0] in_data;

  logic          a_rdy [2];
  logic          a_ov  [2];
  logic [BW-1:0] a_od  [2];
  logic [1:0]    a_occ [2];
  logic [15:0]   a_sc  [2];

  int checks = 0;
  int errors = 0;

  // Reference model: per instance an ordered list of held entries (max 2 / 1).
  logic [BW-1:0] m_ent  [2][2];
  int            m_n    [2];
  logic [BW-1:0] m_last [2];
  int            m_stall[2];

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .NUM_CH(NCH), .SKID_EN(1'b1), .CLR_VAL(CLRV)) u_dut_skid (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(a_rdy[0]), .out_valid(a_ov[0]), .out_data(a_od[0]), .out_ready(out_ready),
    .occ(a_occ[0]), .stall_cnt(a_sc[0])
  );

  pipe_stage_skid #(.DATA_W(DW), .NUM_CH(NCH), .SKID_EN(1'b0), .CLR_VAL(CLRV)) u_dut_noskid (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(a_rdy[1]), .out_valid(a_ov[1]), .out_data(a_od[1]), .out_ready(out_ready),
    .occ(a_occ[1]), .stall_cnt(a_sc[1])
  );

  function automatic logic [BW-1:0] mk(input logic [31:0] c0, input logic [31:0] c1,
                                       input logic [31:0] c2);
    return {c2, c1, c0};
  endfunction

  function automatic logic m_ready(input int k);
    if (k == 0) return en && (m_n[k] < 2);
    return en && ((m_n[k] == 0) || out_ready);
  endfunction

  function automatic logic [BW-1:0] m_data(input int k);
    return (m_n[k] > 0) ? m_ent[k][0] : m_last[k];
  endfunction

  // Advance one clock edge and the model alongside it.
  task automatic tick();
    logic r [2];
    for (int k = 0; k < 2; k++) r[k] = m_ready(k);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_n[k] = 0; m_last[k] = CLRB; m_stall[k] = 0;
      end else if (clr) begin
        m_n[k] = 0; m_last[k] = CLRB;
      end else if (en) begin
        if (m_n[k] > 0 && !out_ready && m_stall[k] < 65535) m_stall[k]++;
        if (m_n[k] > 0 && out_ready) begin
          m_last[k] = m_ent[k][0];
          m_ent[k][0] = m_ent[k][1];
          m_n[k]--;
        end
        if (in_valid && r[k]) begin
          m_ent[k][m_n[k]] = in_data;
          m_n[k]++;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; clr = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; en = 1'b0; in_valid = 1'b1; in_data = mk(1, 2, 3);
    tick(); tick();
    reset = 1'b0; en = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks += 5;
      if (a_ov[k] !== 1'b0) begin errors++; $display("FAIL reset_ov dut%0d got %b exp 0", k, a_ov[k]); end
      if (a_occ[k] !== 2'd0) begin errors++; $display("FAIL reset_occ dut%0d got %0d exp 0", k, a_occ[k]); end
      if (a_sc[k] !== 16'd0) begin errors++; $display("FAIL reset_sc dut%0d got %0d exp 0", k, a_sc[k]); end
      if (a_od[k] !== CLRB) begin errors++; $display("FAIL reset_od dut%0d got %h exp %h", k, a_od[k], CLRB); end
      if (a_rdy[k] !== 1'b1) begin errors++; $display("FAIL reset_rdy dut%0d got %b exp 1", k, a_rdy[k]); end
    end
  endtask

  task automatic test_stream();
    logic [BW-1:0] exp_d;
    do_reset();
    en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (a_ov[k] !== 1'b0) begin errors++; $display("FAIL stream_pre_ov dut%0d got %b exp 0", k, a_ov[k]); end
    end
    for (int i = 0; i < 4; i++) begin
      exp_d = mk(32'h11 + i, 32'h22 + i, 32'h33 + i);
      in_data = exp_d;
      tick();
      for (int k = 0; k < 2; k++) begin
        checks += 4;
        if (a_ov[k] !== 1'b1) begin errors++; $display("FAIL stream_ov dut%0d got %b exp 1", k, a_ov[k]); end
        if (a_od[k] !== exp_d) begin errors++; $display("FAIL stream_od dut%0d got %h exp %h", k, a_od[k], exp_d); end
        if (a_occ[k] !== 2'd1) begin errors++; $display("FAIL stream_occ dut%0d got %0d exp 1", k, a_occ[k]); end
        if (a_sc[k] !== 16'd0) begin errors++; $display("FAIL stream_sc dut%0d got %0d exp 0", k, a_sc[k]); end
      end
    end
  endtask

  task automatic fill_skid(input logic [BW-1:0] a, input logic [BW-1:0] b);
    do_reset();
    in_valid = 1'b1; out_ready = 1'b0; in_data = a;
    tick();
    in_data = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_skid_order();
    logic [BW-1:0] a, b;
    a = mk(32'hA, 32'hA0, 32'hA00);
    b = mk(32'hB, 32'hB0, 32'hB00);
    fill_skid(a, b);
    #1;
    checks += 4;
    if (a_occ[0] !== 2'd2) begin errors++; $display("FAIL skid_occ got %0d exp 2", a_occ[0]); end
    if (a_rdy[0] !== 1'b0) begin errors++; $display("FAIL skid_rdy got %b exp 0", a_rdy[0]); end
    if (a_od[0] !== a) begin errors++; $display("FAIL skid_head got %h exp %h", a_od[0], a); end
    if (a_occ[1] !== 2'd1) begin errors++; $display("FAIL noskid_occ got %0d exp 1", a_occ[1]); end
    out_ready = 1'b1;
    tick();
    checks += 2;
    if (a_od[0] !== b) begin errors++; $display("FAIL skid_second got %h exp %h", a_od[0], b); end
    if (a_occ[0] !== 2'd1) begin errors++; $display("FAIL skid_occ1 got %0d exp 1", a_occ[0]); end
    tick();
    checks += 3;
    if (a_ov[0] !== 1'b0) begin errors++; $display("FAIL skid_drain_ov got %b exp 0", a_ov[0]); end
    if (a_od[0] !== b) begin errors++; $display("FAIL skid_hold_od got %h exp %h", a_od[0], b); end
    if (a_sc[0] !== 16'd1) begin errors++; $display("FAIL skid_sc got %0d exp 1", a_sc[0]); end
  endtask

  task automatic test_flush();
    fill_skid(mk(1, 2, 3), mk(4, 5, 6));
    clr = 1'b1; in_valid = 1'b1; in_data = mk(7, 8, 9); out_ready = 1'b0;
    #1;
    checks++;
    if (a_rdy[0] !== 1'b0) begin errors++; $display("FAIL flush_rdy got %b exp 0", a_rdy[0]); end
    tick();
    clr = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks += 4;
      if (a_occ[k] !== 2'd0) begin errors++; $display("FAIL flush_occ dut%0d got %0d exp 0", k, a_occ[k]); end
      if (a_ov[k] !== 1'b0) begin errors++; $display("FAIL flush_ov dut%0d got %b exp 0", k, a_ov[k]); end
      if (a_od[k] !== CLRB) begin errors++; $display("FAIL flush_od dut%0d got %h exp %h", k, a_od[k], CLRB); end
      if (a_sc[k] !== 16'd1) begin errors++; $display("FAIL flush_sc dut%0d got %0d exp 1", k, a_sc[k]); end
    end
  endtask

  task automatic test_stall_en();
    logic [BW-1:0] five;
    five = mk(5, 5, 5);
    do_reset();
    in_valid = 1'b1; in_data = five; out_ready = 1'b0;
    tick();
    en = 1'b0; out_ready = 1'b1; in_data = mk(6, 6, 6);
    for (int i = 0; i < 3; i++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (a_rdy[k] !== 1'b0) begin errors++; $display("FAIL stall_rdy dut%0d got %b exp 0", k, a_rdy[k]); end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        checks += 3;
        if (a_od[k] !== five) begin errors++; $display("FAIL stall_od dut%0d got %h exp %h", k, a_od[k], five); end
        if (a_occ[k] !== 2'd1) begin errors++; $display("FAIL stall_occ dut%0d got %0d exp 1", k, a_occ[k]); end
        if (a_ov[k] !== 1'b1) begin errors++; $display("FAIL stall_ov dut%0d got %b exp 1", k, a_ov[k]); end
      end
    end
    en = 1'b1; in_valid = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks += 2;
      if (a_ov[k] !== 1'b0) begin errors++; $display("FAIL unstall_pop dut%0d got %b exp 0", k, a_ov[k]); end
      if (a_od[k] !== five) begin errors++; $display("FAIL unstall_od dut%0d got %h exp %h", k, a_od[k], five); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      clr       = ($urandom_range(0, 59) == 0);
      en        = ($urandom_range(0, 7) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = {$urandom, $urandom, $urandom};
      #1;
      for (int k = 0; k < 2; k++) begin
        checks += 5;
        if (a_rdy[k] !== m_ready(k)) begin errors++; $display("FAIL rnd_rdy dut%0d cyc %0d got %b exp %b", k, i, a_rdy[k], m_ready(k)); end
        if (a_ov[k] !== (m_n[k] > 0)) begin errors++; $display("FAIL rnd_ov dut%0d cyc %0d got %b exp %b", k, i, a_ov[k], m_n[k] > 0); end
        if (a_od[k] !== m_data(k)) begin errors++; $display("FAIL rnd_od dut%0d cyc %0d got %h exp %h", k, i, a_od[k], m_data(k)); end
        if (a_occ[k] !== 2'(m_n[k])) begin errors++; $display("FAIL rnd_occ dut%0d cyc %0d got %0d exp %0d", k, i, a_occ[k], m_n[k]); end
        if (a_sc[k] !== 16'(m_stall[k])) begin errors++; $display("FAIL rnd_sc dut%0d cyc %0d got %0d exp %0d", k, i, a_sc[k], m_stall[k]); end
      end
      tick();
    end
  endtask

  task automatic test_saturate();
    do_reset();
    in_valid = 1'b1; in_data = mk(9, 9, 9);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 70000; i++) tick();
    for (int k = 0; k < 2; k++) begin
      checks += 2;
      if (a_sc[k] !== 16'hFFFF) begin errors++; $display("FAIL sat_sc dut%0d got %h exp ffff", k, a_sc[k]); end
      if (a_sc[k] !== 16'(m_stall[k])) begin errors++; $display("FAIL sat_model dut%0d got %h exp %h", k, a_sc[k], m_stall[k]); end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (a_sc[k] !== 16'd0) begin errors++; $display("FAIL sat_reset dut%0d got %0d exp 0", k, a_sc[k]); end
    end
  endtask

  task automatic test_noskid_comb();
    logic [BW-1:0] two;
    two = mk(2, 2, 2);
    do_reset();
    in_valid = 1'b1; in_data = mk(1, 1, 1); out_ready = 1'b0;
    tick();
    in_data = two;
    #1;
    checks++;
    if (a_rdy[1] !== 1'b0) begin errors++; $display("FAIL comb_rdy_lo got %b exp 0", a_rdy[1]); end
    out_ready = 1'b1;
    #1;
    checks++;
    if (a_rdy[1] !== 1'b1) begin errors++; $display("FAIL comb_rdy_hi got %b exp 1", a_rdy[1]); end
    out_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    checks += 2;
    if (a_od[1] !== two) begin errors++; $display("FAIL comb_load got %h exp %h", a_od[1], two); end
    if (a_occ[1] !== 2'd1) begin errors++; $display("FAIL comb_occ got %0d exp 1", a_occ[1]); end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0; m_last[k] = CLRB; m_stall[k] = 0;
      m_ent[k][0] = '0; m_ent[k][1] = '0;
    end
    idle_inputs();
    #1;
    test_reset();
    test_stream();
    test_skid_order();
    test_flush();
    test_stall_en();
    test_noskid_comb();
    test_random();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
